// File: rtl/z80db_pkg.sv
// Shared types and constants for the Z80 cache loader.
// State encoding, cache SRAM address width and default SRAM write timing.
package z80db_pkg;

    localparam int CACHE_ADDR_W     = 15;
    localparam int DEF_SETUP_CYCLES = 1;
    localparam int DEF_WE_CYCLES    = 2;
    localparam int LDR_CNT_W        = 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        SETUP,
        STROBE,
        HOLD,
        REL
    } ldr_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level, with selectable reset value.
// Latency 2 clocks; no backpressure.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/z80_cache_loader.sv
// Streams a host byte image into cache SRAM while holding the Z80 bus; optional csum port (CACHE_LOADER_CHECKSUM_EN).
// Latency: 1 + SETUP_CYCLES + WE_CYCLES + 1 clocks per byte once BUSAK is seen.
// Backpressure: s_ready is only high in WAIT, so the stream stalls while a byte is being written.
module z80_cache_loader
    import z80db_pkg::*;
#(
    parameter int ADDR_W       = CACHE_ADDR_W,
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int WE_CYCLES    = DEF_WE_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              busrq_n,
    input  logic              busak_n,
    output logic [ADDR_W-1:0] sram_a,
    output logic [7:0]        sram_d_o,
    output logic              sram_d_oe,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef CACHE_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]        csum
`endif
);

    localparam logic [LDR_CNT_W-1:0] SETUP_LAST = LDR_CNT_W'(SETUP_CYCLES - 1);
    localparam logic [LDR_CNT_W-1:0] WE_LAST    = LDR_CNT_W'(WE_CYCLES - 1);
    localparam logic [ADDR_W-1:0]    ADDR_TOP   = '1;

    ldr_state_t           r_state;
    logic [LDR_CNT_W-1:0] r_cnt;
    logic [ADDR_W-1:0]    r_addr;
    logic [7:0]           r_d_o;
    logic                 r_d_oe;
    logic                 r_ce_n;
    logic                 r_we_n;
    logic                 r_busrq_n;
    logic                 r_s_ready;
    logic                 r_last;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
`ifdef CACHE_LOADER_CHECKSUM_EN
    logic [7:0]           r_csum;
`endif

    logic                 w_busak_n_s;

    sync2 #(
        .RST_VAL (1'b1)
    ) u_busak_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_d     (busak_n),
        .o_q     (w_busak_n_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_d_o     <= '0;
            r_d_oe    <= 1'b0;
            r_ce_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_busrq_n <= 1'b1;
            r_s_ready <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
`ifdef CACHE_LOADER_CHECKSUM_EN
            r_csum    <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= REQ;
                        r_addr    <= start_addr;
                        r_err     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_busrq_n <= 1'b0;
`ifdef CACHE_LOADER_CHECKSUM_EN
                        r_csum    <= '0;
`endif
                    end
                end
                REQ: begin
                    if (!w_busak_n_s) begin
                        r_state   <= WAIT;
                        r_s_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    // ce_n falls here; we_n is held off until SETUP has elapsed
                    if (s_valid && r_s_ready) begin
                        r_s_ready <= 1'b0;
                        r_d_o     <= s_data;
                        r_last    <= s_last;
                        r_d_oe    <= 1'b1;
                        r_ce_n    <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_cnt   <= '0;
                        r_we_n  <= 1'b0;
                        r_state <= STROBE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STROBE: begin
                    if (r_cnt == WE_LAST) begin
                        r_we_n  <= 1'b1;
                        r_state <= HOLD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    r_ce_n <= 1'b1;
                    r_d_oe <= 1'b0;
`ifdef CACHE_LOADER_CHECKSUM_EN
                    r_csum <= r_csum + r_d_o;
`endif
                    // the address never wraps: an unterminated image at the top aborts with err
                    if (r_last) begin
                        r_busrq_n <= 1'b1;
                        r_state   <= REL;
                    end else if (r_addr == ADDR_TOP) begin
                        r_err     <= 1'b1;
                        r_busrq_n <= 1'b1;
                        r_state   <= REL;
                    end else begin
                        r_addr    <= r_addr + 1'b1;
                        r_s_ready <= 1'b1;
                        r_state   <= WAIT;
                    end
                end
                REL: begin
                    if (w_busak_n_s) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_ready   = r_s_ready;
    assign busrq_n   = r_busrq_n;
    assign sram_a    = r_addr;
    assign sram_d_o  = r_d_o;
    assign sram_d_oe = r_d_oe;
    assign sram_ce_n = r_ce_n;
    assign sram_we_n = r_we_n;
    assign sram_oe_n = 1'b1;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
`ifdef CACHE_LOADER_CHECKSUM_EN
    assign csum      = r_csum;
`endif

endmodule

// File: tb/tb_z80_cache_loader.sv
// Bench for z80_cache_loader: Z80 BUSAK responder, SRAM model with write-window timing monitor,
// randomized stream loads scored against an image model derived from start address and length.
module tb_z80_cache_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [14:0] start_addr = '0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        busrq_n;
    logic        busak_n = 1'b1;
    logic [14:0] sram_a;
    logic [7:0]  sram_d_o;
    logic        sram_d_oe;
    logic        sram_ce_n;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        busy;
    logic        done;
    logic        err;
`ifdef CACHE_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    z80_cache_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .busrq_n    (busrq_n),
        .busak_n    (busak_n),
        .sram_a     (sram_a),
        .sram_d_o   (sram_d_o),
        .sram_d_oe  (sram_d_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
`ifdef CACHE_LOADER_CHECKSUM_EN
        ,
        .csum       (csum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Bus-acknowledge responder
    int ack_delay = 3;
    bit hold_ack  = 1'b0;
    int ack_cnt   = 0;
    always @(negedge clk) begin
        if (busrq_n) begin
            busak_n = 1'b1;
            ack_cnt = 0;
        end else if (hold_ack) begin
            busak_n = 1'b1;
        end else if (ack_cnt >= ack_delay) begin
            busak_n = 1'b0;
        end else begin
            ack_cnt++;
        end
    end

    // SRAM model and write-window monitor (expects ce_n low 4 clk, we_n low 2 clk from the 2nd clk)
    logic [7:0]  mem [0:32767];
    int          wr_cnt = 0, proto_err = 0, done_cnt = 0, sready_hi = 0, busrq_hi = 0, ce_fall_cnt = 0;
    bit          prev_ce_n = 1'b1, prev_we_n = 1'b1;
    int          ce_len = 0, we_len = 0, we_off = -1;
    logic [14:0] win_a = '0;
    logic [7:0]  win_d = '0;
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (s_ready) sready_hi++;
        if (busrq_n) busrq_hi++;
        if (!sram_ce_n) begin
            if (prev_ce_n) begin
                ce_len = 0; we_len = 0; we_off = -1;
                win_a = sram_a; win_d = sram_d_o;
                ce_fall_cnt++;
            end
            ce_len++;
            if (sram_a !== win_a || sram_d_o !== win_d || sram_d_oe !== 1'b1 || s_ready) proto_err++;
            if (!sram_we_n) begin
                if (we_len == 0) we_off = ce_len - 1;
                else if (prev_we_n) proto_err++;
                we_len++;
            end
        end else begin
            if (!sram_we_n) proto_err++;
            if (!prev_ce_n) begin
                if (ce_len != 4 || we_len != 2 || we_off != 1) proto_err++;
                mem[win_a] = win_d;
                wr_cnt++;
            end
        end
        prev_ce_n = sram_ce_n;
        prev_we_n = sram_we_n;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] ld_data [0:15];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_load(input logic [14:0] addr, input int n, input bit with_last,
                           input int gapmax, input int bound, output int acc, output bit done_tmo);
        int d0;
        int w;
        d0 = done_cnt;
        start = 1'b1;
        start_addr = addr;
        tick();
        start = 1'b0;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gapmax, 0)) tick();
            s_valid = 1'b1;
            s_data  = ld_data[i];
            s_last  = with_last && (i == n - 1);
            w = 0;
            while (!s_ready && w < bound) begin
                tick();
                w++;
            end
            if (!s_ready) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                break;
            end
            tick();
            s_valid = 1'b0;
            s_last  = 1'b0;
            acc++;
        end
        w = 0;
        while (done_cnt == d0 && w < bound) begin
            tick();
            w++;
        end
        done_tmo = (done_cnt == d0);
        tick();
    endtask

    // Image model: bytes land from addr upward, stopping at the last flag or the top address
    function automatic int model_acc(input int addr, input int n);
        int room;
        room = 32768 - addr;
        return (n < room) ? n : room;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busrq_n, sram_ce_n, sram_we_n, sram_oe_n, sram_d_oe, s_ready, busy, done, err} !== 9'b111100000)
            $display("FAIL reset_ctrl: got %b expected 111100000",
                     {busrq_n, sram_ce_n, sram_we_n, sram_oe_n, sram_d_oe, s_ready, busy, done, err});
        else passed++;
        checks++;
        if (sram_a !== 15'h0000 || sram_d_o !== 8'h00)
            $display("FAIL reset_bus: got a=%h d=%h expected a=0000 d=00", sram_a, sram_d_o);
        else passed++;
`ifdef CACHE_LOADER_CHECKSUM_EN
        checks++;
        if (csum !== 8'h00) $display("FAIL reset_csum: got %h expected 00", csum);
        else passed++;
`endif
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int acc; bit tmo; int w0, d0, p0;
        logic [7:0] exp_b [0:3];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            ld_data[i] = exp_b[i];
            mem[i] = ~exp_b[i];
        end
        ack_delay = 3;
        w0 = wr_cnt; d0 = done_cnt; p0 = proto_err;
        do_load(15'h0000, 4, 1'b1, 2, 300, acc, tmo);
        checks++;
        if (acc !== 4 || tmo !== 1'b0) $display("FAIL basic_accept: got acc=%0d tmo=%0d expected acc=4 tmo=0", acc, tmo);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[i] !== exp_b[i]) $display("FAIL basic_mem[%0d]: got %h expected %h", i, mem[i], exp_b[i]);
            else passed++;
        end
        checks++;
        if (wr_cnt - w0 !== 4 || done_cnt - d0 !== 1)
            $display("FAIL basic_counts: got writes=%0d dones=%0d expected 4 and 1", wr_cnt - w0, done_cnt - d0);
        else passed++;
        checks++;
        if ({busrq_n, err, busy} !== 3'b100) $display("FAIL basic_final: got busrq_n/err/busy=%b expected 100", {busrq_n, err, busy});
        else passed++;
        checks++;
        if (proto_err - p0 !== 0) $display("FAIL basic_timing: got %0d window violations expected 0", proto_err - p0);
        else passed++;
    endtask

    task automatic test_timing();
        int acc; bit tmo; int p0, c0;
        for (int i = 0; i < 6; i++) ld_data[i] = 8'($urandom);
        ack_delay = 0;
        p0 = proto_err; c0 = ce_fall_cnt;
        do_load(15'h0400, 6, 1'b1, 0, 300, acc, tmo);
        checks++;
        if (proto_err - p0 !== 0 || ce_fall_cnt - c0 !== 6)
            $display("FAIL timing_windows: got violations=%0d windows=%0d expected 0 and 6", proto_err - p0, ce_fall_cnt - c0);
        else passed++;
    endtask

    task automatic test_overflow();
        int acc; bit tmo; int w0, d0, s0;
        for (int i = 0; i < 3; i++) ld_data[i] = 8'($urandom);
        mem[32766] = ~ld_data[0];
        mem[32767] = ~ld_data[1];
        ack_delay = 2;
        w0 = wr_cnt; d0 = done_cnt;
        do_load(15'h7FFE, 3, 1'b0, 1, 60, acc, tmo);
        checks++;
        if (acc !== model_acc(32766, 3) || tmo !== 1'b0)
            $display("FAIL ovf_accept: got acc=%0d tmo=%0d expected acc=%0d tmo=0", acc, tmo, model_acc(32766, 3));
        else passed++;
        checks++;
        if (mem[32766] !== ld_data[0] || mem[32767] !== ld_data[1])
            $display("FAIL ovf_mem: got %h %h expected %h %h", mem[32766], mem[32767], ld_data[0], ld_data[1]);
        else passed++;
        checks++;
        if (err !== 1'b1 || wr_cnt - w0 !== 2 || done_cnt - d0 !== 1)
            $display("FAIL ovf_status: got err=%0d writes=%0d dones=%0d expected 1, 2, 1", err, wr_cnt - w0, done_cnt - d0);
        else passed++;
        s0 = sready_hi;
        s_valid = 1'b1;
        repeat (20) tick();
        s_valid = 1'b0;
        checks++;
        if (sready_hi - s0 !== 0 || err !== 1'b1)
            $display("FAIL ovf_after: got s_ready cycles=%0d err=%0d expected 0 and 1", sready_hi - s0, err);
        else passed++;
    endtask

    task automatic test_no_ack();
        int acc; bit tmo;
        ld_data[0] = 8'hA5; ld_data[1] = 8'h5A;
        mem[16'h1234] = 8'h00; mem[16'h1235] = 8'h00;
        ack_delay = 1;
        hold_ack = 1'b1;
        fork
            do_load(15'h1234, 2, 1'b1, 0, 400, acc, tmo);
            begin
                int s0, c0, b0;
                tick();
                s0 = sready_hi; c0 = ce_fall_cnt; b0 = busrq_hi;
                repeat (100) tick();
                checks++;
                if (sready_hi - s0 !== 0 || ce_fall_cnt - c0 !== 0 || busrq_hi - b0 !== 0)
                    $display("FAIL noack_stall: got s_ready=%0d strobes=%0d busrq_n_high=%0d expected all 0",
                             sready_hi - s0, ce_fall_cnt - c0, busrq_hi - b0);
                else passed++;
                checks++;
                if (err !== 1'b0 || busy !== 1'b1)
                    $display("FAIL noack_state: got err=%0d busy=%0d expected 0 and 1", err, busy);
                else passed++;
                hold_ack = 1'b0;
            end
        join
        checks++;
        if (acc !== 2 || tmo !== 1'b0 || mem[16'h1234] !== 8'hA5 || mem[16'h1235] !== 8'h5A)
            $display("FAIL noack_resume: got acc=%0d tmo=%0d mem=%h %h expected 2 0 a5 5a",
                     acc, tmo, mem[16'h1234], mem[16'h1235]);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int acc; bit tmo; int w;
        ack_delay = 1;
        start = 1'b1; start_addr = 15'h0040;
        tick();
        start = 1'b0;
        s_valid = 1'b1; s_data = 8'hC3; s_last = 1'b0;
        w = 0;
        while (sram_we_n && w < 100) begin
            tick();
            w++;
        end
        checks++;
        if (sram_we_n !== 1'b0) $display("FAIL rstmid_reach: got we_n=%b expected 0 within 100 clk", sram_we_n);
        else passed++;
        reset = 1'b1;
        s_valid = 1'b0;
        tick();
        checks++;
        if ({busrq_n, sram_ce_n, sram_we_n, sram_d_oe, busy, s_ready} !== 6'b111000)
            $display("FAIL rstmid_outputs: got %b expected 111000",
                     {busrq_n, sram_ce_n, sram_we_n, sram_d_oe, busy, s_ready});
        else passed++;
        reset = 1'b0;
        repeat (2) tick();
        ld_data[0] = 8'h9E; ld_data[1] = 8'h7B;
        mem[16'h0050] = 8'h00; mem[16'h0051] = 8'h00;
        do_load(15'h0050, 2, 1'b1, 1, 300, acc, tmo);
        checks++;
        if (acc !== 2 || tmo !== 1'b0 || mem[16'h0050] !== 8'h9E || mem[16'h0051] !== 8'h7B || err !== 1'b0)
            $display("FAIL rstmid_restart: got acc=%0d tmo=%0d mem=%h %h err=%0d expected 2 0 9e 7b 0",
                     acc, tmo, mem[16'h0050], mem[16'h0051], err);
        else passed++;
    endtask

    task automatic test_random();
        int acc, acc_exp, n, room, w0, d0, p0, a;
        bit tmo, last, err_exp;
        logic [7:0] sum;
        for (int it = 0; it < 8; it++) begin
            if (it % 4 == 3) begin
                room = $urandom_range(4, 1);
                a = 32768 - room;
                n = room + 1;
                last = 1'b0;
            end else begin
                n = $urandom_range(8, 1);
                a = $urandom_range(32760, 0);
                last = 1'b1;
            end
            for (int i = 0; i < n; i++) begin
                ld_data[i] = 8'($urandom);
                if (a + i < 32768) mem[a + i] = ~ld_data[i];
            end
            ack_delay = $urandom_range(6, 0);
            acc_exp = model_acc(a, n);
            err_exp = !(last && acc_exp == n);
            sum = '0;
            for (int i = 0; i < acc_exp; i++) sum = sum + ld_data[i];
            w0 = wr_cnt; d0 = done_cnt; p0 = proto_err;
            do_load(15'(a), n, last, 3, last ? 300 : 60, acc, tmo);
            checks++;
            if (acc !== acc_exp || tmo !== 1'b0 || err !== err_exp)
                $display("FAIL rand%0d_status: got acc=%0d tmo=%0d err=%0d expected %0d 0 %0d",
                         it, acc, tmo, err, acc_exp, err_exp);
            else passed++;
            for (int i = 0; i < acc_exp; i++) begin
                checks++;
                if (mem[a + i] !== ld_data[i])
                    $display("FAIL rand%0d_mem[%h]: got %h expected %h", it, a + i, mem[a + i], ld_data[i]);
                else passed++;
            end
            checks++;
            if (wr_cnt - w0 !== acc_exp || done_cnt - d0 !== 1 || proto_err - p0 !== 0)
                $display("FAIL rand%0d_counts: got writes=%0d dones=%0d violations=%0d expected %0d 1 0",
                         it, wr_cnt - w0, done_cnt - d0, proto_err - p0, acc_exp);
            else passed++;
`ifdef CACHE_LOADER_CHECKSUM_EN
            checks++;
            if (csum !== sum) $display("FAIL rand%0d_csum: got %h expected %h", it, csum, sum);
            else passed++;
`endif
        end
    endtask

    task automatic test_checksum_busy();
        int acc; bit tmo; int w0, d0;
        ld_data[0] = 8'hFF; ld_data[1] = 8'h02;
        mem[16'h0100] = 8'h00; mem[16'h0101] = 8'h00; mem[16'h0200] = 8'h5A;
        ack_delay = 3;
        w0 = wr_cnt; d0 = done_cnt;
        fork
            do_load(15'h0100, 2, 1'b1, 0, 300, acc, tmo);
            begin
                repeat (6) tick();
                checks++;
                if (busy !== 1'b1) $display("FAIL busy_during: got busy=%0d expected 1", busy);
                else passed++;
                start = 1'b1; start_addr = 15'h0200;
                tick();
                start = 1'b0;
            end
        join
        checks++;
        if (acc !== 2 || tmo !== 1'b0 || mem[16'h0100] !== 8'hFF || mem[16'h0101] !== 8'h02)
            $display("FAIL busy_load: got acc=%0d tmo=%0d mem=%h %h expected 2 0 ff 02",
                     acc, tmo, mem[16'h0100], mem[16'h0101]);
        else passed++;
        repeat (40) tick();
        checks++;
        if (mem[16'h0200] !== 8'h5A || wr_cnt - w0 !== 2 || done_cnt - d0 !== 1 || busy !== 1'b0)
            $display("FAIL busy_ignored: got mem200=%h writes=%0d dones=%0d busy=%0d expected 5a 2 1 0",
                     mem[16'h0200], wr_cnt - w0, done_cnt - d0, busy);
        else passed++;
`ifdef CACHE_LOADER_CHECKSUM_EN
        checks++;
        if (csum !== 8'h01) $display("FAIL csum_ff02: got %h expected 01", csum);
        else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timing();
        test_overflow();
        test_no_ack();
        test_reset_mid();
        test_random();
        test_checksum_busy();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
